wbu_csr_file_ysyx_23060136: RTL and testbench

//  Machine-mode CSR register file, the write/read end of the IDU CSR index decode.

---
 rtl/wbu_csr_file_ysyx_23060136.sv | 195 +++++++++++++++++++
 tb/tb_wbu_csr_file_ysyx_23060136.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wbu_csr_file_ysyx_23060136.sv
// Machine-mode CSR file: combinational read port, commit port for csrw/ecall/mret, trap/return PC redirect.
// Optional same-cycle write-to-read forwarding when CSR_BYPASS_EN is defined.
module wbu_csr_file_ysyx_23060136 #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800,
  parameter logic [XLEN-1:0] MVENDORID   = 32'h7973_7978,
  parameter logic [XLEN-1:0] MARCHID     = 32'h015F_DEA8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      csr_rs_idx,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic [2:0]      commit_csr_rd,
  input  logic            commit_wen,
  input  logic [XLEN-1:0] commit_wdata,
  input  logic            commit_ecall,
  input  logic            commit_mret,
  input  logic [XLEN-1:0] commit_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [2:0] CSR_MSTATUS   = 3'd0;
  localparam logic [2:0] CSR_MTVEC     = 3'd1;
  localparam logic [2:0] CSR_MEPC      = 3'd2;
  localparam logic [2:0] CSR_MCAUSE    = 3'd3;
  localparam logic [2:0] CSR_MVENDORID = 3'd4;
  localparam logic [2:0] CSR_MARCHID   = 3'd5;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] CAUSE_ECALL_M = XLEN'(11);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_TRAP_EPC   = 2'd1,
    S_TRAP_CAUSE = 2'd2,
    S_RET        = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] epc_q, epc_d;

  logic            fire;
  logic            take_ecall;
  logic            take_mret;
  logic            take_wen;
  logic [XLEN-1:0] wr_val;

  assign fire       = commit_valid & commit_ready;
  assign take_ecall = fire & commit_ecall;
  assign take_mret  = fire & ~commit_ecall & commit_mret;
  assign take_wen   = fire & ~commit_ecall & ~commit_mret & commit_wen;

  // mtvec/mepc hold word-aligned addresses; other CSRs store the raw value
  always_comb begin
    wr_val = commit_wdata;
    if (commit_csr_rd == CSR_MTVEC || commit_csr_rd == CSR_MEPC) begin
      wr_val = commit_wdata & ALIGN_MASK;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (take_ecall) begin
          state_d = S_TRAP_EPC;
        end else if (take_mret) begin
          state_d = S_RET;
        end
      end
      S_TRAP_EPC:   state_d = S_TRAP_CAUSE;
      S_TRAP_CAUSE: state_d = S_IDLE;
      S_RET:        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    commit_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = mtvec_q;
    unique case (state_q)
      S_IDLE:       commit_ready = ~rst;
      S_TRAP_EPC:   redirect_valid = 1'b0;
      S_TRAP_CAUSE: begin
        redirect_valid = ~rst;
        redirect_pc    = mtvec_q;
      end
      S_RET: begin
        redirect_valid = ~rst;
        redirect_pc    = mepc_q;
      end
      default: redirect_valid = 1'b0;
    endcase
  end

  // ---------------- CSR next-state ----------------
  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    epc_d     = epc_q;

    if (take_ecall) begin
      epc_d = commit_pc;
    end

    if (take_wen) begin
      unique case (commit_csr_rd)
        CSR_MSTATUS: mstatus_d = wr_val;
        CSR_MTVEC:   mtvec_d   = wr_val;
        CSR_MEPC:    mepc_d    = wr_val;
        CSR_MCAUSE:  mcause_d  = wr_val;
        default:     mstatus_d = mstatus_q;
      endcase
    end

    if (take_mret) begin
      mstatus_d[MIE_BIT]  = mstatus_q[MPIE_BIT];
      mstatus_d[MPIE_BIT] = 1'b1;
      mstatus_d[12:11]    = 2'b11;
    end

    if (state_q == S_TRAP_EPC) begin
      mepc_d = epc_q & ALIGN_MASK;
    end

    if (state_q == S_TRAP_CAUSE) begin
      mcause_d            = CAUSE_ECALL_M;
      mstatus_d[MPIE_BIT] = mstatus_q[MIE_BIT];
      mstatus_d[MIE_BIT]  = 1'b0;
      mstatus_d[12:11]    = 2'b11;
    end
  end

  // Reset wins over any in-flight trap/return update
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      epc_q     <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      epc_q     <= epc_d;
    end
  end

  // ---------------- read port ----------------
  always_comb begin
    csr_rdata = '0;
    unique case (csr_rs_idx)
      CSR_MSTATUS:   csr_rdata = mstatus_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MVENDORID: csr_rdata = MVENDORID;
      CSR_MARCHID:   csr_rdata = MARCHID;
      default:       csr_rdata = '0;
    endcase
`ifdef CSR_BYPASS_EN
    if (take_wen && (commit_csr_rd == csr_rs_idx) && (commit_csr_rd <= CSR_MCAUSE)) begin
      csr_rdata = wr_val;
    end
`endif
  end

endmodule

// File: tb/tb_wbu_csr_file_ysyx_23060136.sv
// Bench for wbu_csr_file_ysyx_23060136: write/read vector table plus ecall/mret/priority/abort/bypass sequences.
// Redirects are checked against a queue of expected {pc, cycle} pushed when the commit is driven.
module tb_wbu_csr_file_ysyx_23060136;

  localparam logic [2:0] I_MSTATUS   = 3'd0;
  localparam logic [2:0] I_MTVEC     = 3'd1;
  localparam logic [2:0] I_MEPC      = 3'd2;
  localparam logic [2:0] I_MCAUSE    = 3'd3;
  localparam logic [2:0] I_MVENDORID = 3'd4;
  localparam logic [2:0] I_MARCHID   = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  csr_rs_idx = '0;
  logic [31:0] csr_rdata;
  logic        commit_valid = 1'b0;
  logic        commit_ready;
  logic [2:0]  commit_csr_rd = '0;
  logic        commit_wen = 1'b0;
  logic [31:0] commit_wdata = '0;
  logic        commit_ecall = 1'b0;
  logic        commit_mret = 1'b0;
  logic [31:0] commit_pc = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  wbu_csr_file_ysyx_23060136 dut (
    .clk           (clk),
    .rst           (rst),
    .csr_rs_idx    (csr_rs_idx),
    .csr_rdata     (csr_rdata),
    .commit_valid  (commit_valid),
    .commit_ready  (commit_ready),
    .commit_csr_rd (commit_csr_rd),
    .commit_wen    (commit_wen),
    .commit_wdata  (commit_wdata),
    .commit_ecall  (commit_ecall),
    .commit_mret   (commit_mret),
    .commit_pc     (commit_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] wdata;
    logic [2:0]  rs;
    logic [31:0] exp;
  } wr_vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   redir_seen = 0;
  logic prev_redir = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: advance past the rising edge, then observe outputs at the falling edge
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (redirect_valid) begin
      redir_seen++;
      check("redirect_not_back_to_back", {31'b0, prev_redir}, 32'd0);
      check("redirect_expected", {31'b0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("redirect_pc", redirect_pc, e.pc);
        check("redirect_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_redir = redirect_valid;
  endtask

  task automatic commit(input logic wen, input logic ecall, input logic mret,
                        input logic [2:0] rd, input logic [31:0] wdata, input logic [31:0] pc,
                        input logic [31:0] exp_pc, input int lat);
    int n;
    n = 0;
    while (!commit_ready && n < 20) begin
      tick();
      n++;
    end
    if (!commit_ready) check("commit_ready_wait", {31'b0, commit_ready}, 32'd1);
    commit_valid  = 1'b1;
    commit_wen    = wen;
    commit_ecall  = ecall;
    commit_mret   = mret;
    commit_csr_rd = rd;
    commit_wdata  = wdata;
    commit_pc     = pc;
    if (lat > 0) sb_q.push_back('{exp_pc, cyc + lat});
    tick();
    commit_valid = 1'b0;
    commit_wen   = 1'b0;
    commit_ecall = 1'b0;
    commit_mret  = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] idx, input logic [31:0] exp);
    csr_rs_idx = idx;
    #1;
    check(name, csr_rdata, exp);
  endtask

  initial begin
    wr_vec_t vecs[9];
    int c0;
    int seen0;
    logic [31:0] byp_exp;

    vecs[0] = '{I_MTVEC,     32'h8000_0103, I_MTVEC,     32'h8000_0100};
    vecs[1] = '{I_MARCHID,   32'hFFFF_FFFF, I_MARCHID,   32'h015F_DEA8};
    vecs[2] = '{I_MVENDORID, 32'h0000_0000, I_MVENDORID, 32'h7973_7978};
    vecs[3] = '{I_MEPC,      32'h1234_5677, I_MEPC,      32'h1234_5674};
    vecs[4] = '{I_MCAUSE,    32'hDEAD_BEEF, I_MCAUSE,    32'hDEAD_BEEF};
    vecs[5] = '{3'd6,        32'hFFFF_FFFF, 3'd6,        32'h0000_0000};
    vecs[6] = '{3'd7,        32'hFFFF_FFFF, 3'd7,        32'h0000_0000};
    vecs[7] = '{3'd7,        32'h0000_0000, I_MTVEC,     32'h8000_0100};
    vecs[8] = '{I_MSTATUS,   32'h0000_1888, I_MSTATUS,   32'h0000_1888};

    // Reset
    tick();
    check("ready_in_reset", {31'b0, commit_ready}, 32'd0);
    check("redirect_in_reset", {31'b0, redirect_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'b0, commit_ready}, 32'd1);
    rd_chk("rst_mstatus", I_MSTATUS, 32'h0000_1800);
    rd_chk("rst_mtvec", I_MTVEC, 32'h0);
    rd_chk("rst_mepc", I_MEPC, 32'h0);
    rd_chk("rst_mcause", I_MCAUSE, 32'h0);

    // Write/read table
    for (int i = 0; i < 9; i++) begin
      commit(1'b1, 1'b0, 1'b0, vecs[i].idx, vecs[i].wdata, 32'h0, 32'h0, 0);
      rd_chk($sformatf("vec%0d_read", i), vecs[i].rs, vecs[i].exp);
    end

    // Ecall: MIE=1, redirect to mtvec two cycles after fire
    commit(1'b1, 1'b0, 1'b0, I_MTVEC, 32'h8000_0100, 32'h0, 32'h0, 0);
    commit(1'b1, 1'b0, 1'b0, I_MSTATUS, 32'h0000_1808, 32'h0, 32'h0, 0);
    c0 = cyc;
    commit(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h8000_0040, 32'h8000_0100, 2);
    check("ecall_ready_n1", {31'b0, commit_ready}, 32'd0);
    tick();
    check("ecall_ready_n2", {31'b0, commit_ready}, 32'd0);
    tick();
    check("ecall_ready_n3", {31'b0, commit_ready}, 32'd1);
    check("ecall_cycles", 32'(cyc - c0), 32'd3);
    rd_chk("ecall_mepc", I_MEPC, 32'h8000_0040);
    rd_chk("ecall_mcause", I_MCAUSE, 32'd11);
    rd_chk("ecall_mstatus", I_MSTATUS, 32'h0000_1880);

    // Mret: redirect to mepc one cycle after fire
    commit(1'b1, 1'b0, 1'b0, I_MEPC, 32'h8000_0044, 32'h0, 32'h0, 0);
    commit(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h8000_0044, 1);
    check("mret_ready_n1", {31'b0, commit_ready}, 32'd0);
    tick();
    check("mret_ready_n2", {31'b0, commit_ready}, 32'd1);
    rd_chk("mret_mstatus", I_MSTATUS, 32'h0000_1888);

    // All three flags together: only the ecall path, the mtvec write is dropped
    commit(1'b1, 1'b1, 1'b1, I_MTVEC, 32'h0000_0000, 32'h8000_0080, 32'h8000_0100, 2);
    tick();
    tick();
    rd_chk("prio_mtvec", I_MTVEC, 32'h8000_0100);
    rd_chk("prio_mepc", I_MEPC, 32'h8000_0080);
    rd_chk("prio_mcause", I_MCAUSE, 32'd11);
    rd_chk("prio_mstatus", I_MSTATUS, 32'h0000_1880);

    // Reset during TRAP_EPC aborts the trap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    commit(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h8000_0200, 32'h0, 0);
    seen0 = redir_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("abort_no_redirect", 32'(redir_seen - seen0), 32'd0);
    check("abort_ready", {31'b0, commit_ready}, 32'd1);
    rd_chk("abort_mcause", I_MCAUSE, 32'h0);
    rd_chk("abort_mepc", I_MEPC, 32'h0);
    rd_chk("abort_mstatus", I_MSTATUS, 32'h0000_1800);

    // Same-cycle write and read of mepc
`ifdef CSR_BYPASS_EN
    byp_exp = 32'h0000_1234;
`else
    byp_exp = 32'h0000_0000;
`endif
    commit_valid  = 1'b1;
    commit_wen    = 1'b1;
    commit_csr_rd = I_MEPC;
    commit_wdata  = 32'h0000_1234;
    rd_chk("bypass_same_cycle", I_MEPC, byp_exp);
    tick();
    commit_valid = 1'b0;
    commit_wen   = 1'b0;
    rd_chk("bypass_after_edge", I_MEPC, 32'h0000_1234);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
